// File: rtl/axis_deadlock_detector.sv
// Stall-qualification FSM over AXI-Stream blocking vectors.
// Raises a sticky block flag and snapshots the stalled streams.
module axis_deadlock_detector #(
  parameter int NUM_AXIS        = 10,
  parameter int NUM_INST        = 1,
  parameter int STALL_THRESHOLD = 1024,
  parameter int CNT_W           = 16,
  parameter int IDX_W           = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_mask,
  output logic [IDX_W-1:0]    first_blocked_idx,
  output logic [CNT_W-1:0]    stall_count
);

  typedef enum logic [1:0] {
    MONITOR,
    SUSPECT,
    DEADLOCK
  } state_t;

  localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(NUM_AXIS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_THRESHOLD);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_AXIS-1:0]   r_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_block;
  logic                  w_block_nxt;
  logic [NUM_AXIS-1:0]   r_mask;
  logic [NUM_AXIS-1:0]   w_mask_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;

  logic w_any_blk;
  logic w_all_idle;
  logic w_progress;
  logic w_stall;

  function automatic logic [IDX_W-1:0] f_prio(
    input logic [NUM_AXIS-1:0] v
  );
    f_prio = NONE_IDX;
    for (int i = NUM_AXIS - 1; i >= 0; i--)
      if (v[i]) f_prio = IDX_W'(i);
  endfunction

  // Any change in the blocking pattern means something moved.
  always_comb begin
    w_any_blk  = (|axis_block_sigs) | (|inst_block_sigs);
    w_all_idle = &inst_idle_sigs;
    w_progress = (axis_block_sigs != r_prev);
    w_stall    = w_any_blk & ~w_all_idle & ~w_progress;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_block_nxt = r_block;
    w_mask_nxt  = r_mask;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      MONITOR: begin
        w_cnt_nxt = '0;
        if (w_stall) begin
          w_state_nxt = SUSPECT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      SUSPECT: begin
        if (!w_stall) begin
          w_state_nxt = MONITOR;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DEADLOCK;
          w_cnt_nxt   = CNT_MAX;
          w_block_nxt = 1'b1;
          w_mask_nxt  = axis_block_sigs;
          w_idx_nxt   = f_prio(axis_block_sigs);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DEADLOCK: begin
        w_block_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = MONITOR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= MONITOR;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_block <= 1'b0;
      r_mask  <= '0;
      r_idx   <= NONE_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= axis_block_sigs;
      r_cnt   <= w_cnt_nxt;
      r_block <= w_block_nxt;
      r_mask  <= w_mask_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign block             = r_block;
  assign block_mask        = r_mask;
  assign first_blocked_idx = r_idx;
  assign stall_count       = r_cnt;

endmodule

// File: tb/tb_axis_deadlock_detector.sv
// Directed bench: threshold-8 instance plus a default-threshold instance.
module tb_axis_deadlock_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] axis;
  logic [0:0] idle;
  logic [0:0] iblk;

  logic        s_block, d_block;
  logic [9:0]  s_mask, d_mask;
  logic [3:0]  s_idx, d_idx;
  logic [15:0] s_cnt, d_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_deadlock_detector #(
    .NUM_AXIS(10), .NUM_INST(1), .STALL_THRESHOLD(8),
    .CNT_W(16), .IDX_W(4)
  ) u_small (
    .clock(clk), .reset(rst),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(iblk),
    .block(s_block), .block_mask(s_mask),
    .first_blocked_idx(s_idx), .stall_count(s_cnt)
  );

  axis_deadlock_detector u_dflt (
    .clock(clk), .reset(rst),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(iblk),
    .block(d_block), .block_mask(d_mask),
    .first_blocked_idx(d_idx), .stall_count(d_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst  = 1'b0;
    axis = '0;
    idle = '0;
    iblk = '0;
  endtask

  task automatic chk_small(input string tag, input logic b,
                           input logic [15:0] c,
                           input logic [9:0] m,
                           input logic [3:0] ix);
    chk({tag, ".block"}, 32'(s_block), 32'(b));
    chk({tag, ".cnt"},   32'(s_cnt),   32'(c));
    chk({tag, ".mask"},  32'(s_mask),  32'(m));
    chk({tag, ".idx"},   32'(s_idx),   32'(ix));
  endtask

  initial begin
    rst  = 1'b1;
    axis = '0;
    idle = '0;
    iblk = '0;

    for (int i = 0; i < 3; i++) begin
      axis = 10'($urandom);
      idle = 1'($urandom);
      iblk = 1'($urandom);
      step(1);
    end
    chk_small("rst", 1'b0, 16'd0, 10'h0, 4'd10);
    chk("rst.d_block", 32'(d_block), 32'd0);
    chk("rst.d_idx",   32'(d_idx),   32'd10);
    rst  = 1'b0;
    axis = '0;
    idle = '0;
    iblk = '0;
    step(1);

    // basic deadlock: 1 progress cycle then 8 stall cycles
    axis = 10'h104;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk($sformatf("basic.cnt%0d", k), 32'(s_cnt),
          (k == 1) ? 32'd0 : (k >= 9 ? 32'd8 : 32'(k - 1)));
      chk($sformatf("basic.blk%0d", k), 32'(s_block),
          (k >= 9) ? 32'd1 : 32'd0);
    end
    chk_small("basic", 1'b1, 16'd8, 10'h104, 4'd2);
    axis = 10'h001;
    iblk = 1'b1;
    step(5);
    chk_small("frozen", 1'b1, 16'd8, 10'h104, 4'd2);

    rst = 1'b1;
    step(1);
    rst  = 1'b0;
    chk_small("rst_dl", 1'b0, 16'd0, 10'h0, 4'd10);
    axis = '0;
    iblk = '0;
    step(1);

    // progress resets count
    axis = 10'h001;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("prog.cnt%0d", k), 32'(s_cnt), 32'(k - 1));
    end
    axis = 10'h002;
    step(1);
    chk_small("prog.chg", 1'b0, 16'd0, 10'h0, 4'd10);
    for (int j = 1; j <= 8; j++) begin
      step(1);
      chk($sformatf("prog.cnt_b%0d", j), 32'(s_cnt), 32'(j));
      chk($sformatf("prog.blk_b%0d", j), 32'(s_block),
          (j == 8) ? 32'd1 : 32'd0);
    end
    chk_small("prog", 1'b1, 16'd8, 10'h002, 4'd1);

    // idle suppression
    do_reset();
    axis = 10'h300;
    idle = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      chk("idle.blk", 32'(s_block), 32'd0);
      chk("idle.cnt", 32'(s_cnt),   32'd0);
    end
    idle = 1'b0;
    step(7);
    chk_small("idle.pre", 1'b0, 16'd7, 10'h0, 4'd10);
    step(1);
    chk_small("idle.dl", 1'b1, 16'd8, 10'h300, 4'd8);

    // instance-only block
    do_reset();
    iblk = 1'b1;
    step(7);
    chk("inst.pre", 32'(s_block), 32'd0);
    step(3);
    chk_small("inst", 1'b1, 16'd8, 10'h0, 4'd10);

    // default threshold instance
    do_reset();
    axis = 10'h3FF;
    step(1024);
    chk("dflt.blk1024", 32'(d_block), 32'd0);
    chk("dflt.cnt1024", 32'(d_cnt),   32'd1023);
    step(1);
    chk("dflt.blk1025", 32'(d_block), 32'd1);
    chk("dflt.cnt1025", 32'(d_cnt),   32'd1024);
    chk("dflt.mask",    32'(d_mask),  32'h3FF);
    chk("dflt.idx",     32'(d_idx),   32'd0);
    step(20);
    chk("dflt.hold", 32'(d_cnt), 32'd1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_deadlock_detector.md
Name: axis_deadlock_detector

Overview:
Per-kernel deadlock detector driven by the kernel monitor top. It consumes the packed AXI-Stream blocking vector (inverted TDATA_blk_n of every in/out stream) plus per-instance idle/block flags. It runs a stall-qualification state machine and asserts a sticky block flag once the kernel has made no observable progress for a programmable number of consecutive cycles. It also latches a diagnostic snapshot identifying the stalled streams.

Parameters:
NUM_AXIS, 10, width of axis_block_sigs (8 complex-pair inputs + out_real/out_imag)
NUM_INST, 1, width of inst_idle_sigs / inst_block_sigs
STALL_THRESHOLD, 1024, consecutive stall cycles required to declare deadlock (>=2)
CNT_W, 16, stall counter width; must satisfy 2**CNT_W > STALL_THRESHOLD
IDX_W, 4, width of first_blocked_idx; must satisfy 2**IDX_W > NUM_AXIS

Ports:
clock  in  1  monitor clock; all state on rising edge
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  NUM_AXIS  bit i = stream i currently blocked
inst_idle_sigs  in  NUM_INST  bit j = instance j idle
inst_block_sigs  in  NUM_INST  bit j = instance j blocked internally
block  out  1  sticky deadlock flag
block_mask  out  NUM_AXIS  axis_block_sigs latched on deadlock entry
first_blocked_idx  out  IDX_W  lowest set index of block_mask; NUM_AXIS if mask is zero
stall_count  out  CNT_W  current consecutive stall count

Behaviour:
- Reset (reset=1 at a clock edge): state=MONITOR, prev_axis=0, stall_count=0, block=0, block_mask=0, first_blocked_idx=NUM_AXIS. Reset overrides every state, including DEADLOCK.
- Combinational qualifiers, evaluated each cycle:
  any_blk = |axis_block_sigs | |inst_block_sigs
  all_idle = &inst_idle_sigs
  progress = (axis_block_sigs != prev_axis)
  stall = any_blk & ~all_idle & ~progress
- prev_axis <= axis_block_sigs every non-reset cycle, in all states. Consequence: the first cycle after reset with a nonzero vector counts as progress, not stall.
- State MONITOR: stall_count=0. On stall, go to SUSPECT with stall_count<=1.
- State SUSPECT:
  - On stall with stall_count == STALL_THRESHOLD-1: go to DEADLOCK, stall_count<=STALL_THRESHOLD, block<=1, block_mask<=axis_block_sigs, first_blocked_idx<=priority-encode(axis_block_sigs), where the lowest index wins and the result is NUM_AXIS if the vector is zero.
  - On any other stall cycle: stall_count<=stall_count+1.
  - On ~stall (progress, all idle, or nothing blocked): go to MONITOR with stall_count<=0.
- State DEADLOCK: terminal until reset. block=1. stall_count, block_mask and first_blocked_idx are frozen. Inputs are ignored except for prev_axis tracking.
- Latency: block rises on the clock edge that samples the STALL_THRESHOLD-th consecutive stall cycle, and is visible the following cycle.
- Simultaneous events:
  - If progress and any_blk occur in the same cycle, progress wins and the counter clears.
  - If all_idle holds, stall is forced low even when block bits are set, because the kernel is finished.
- A stall caused only by inst_block_sigs (axis vector constant and zero) is valid. It yields block_mask=0 and first_blocked_idx=NUM_AXIS.
- stall_count never wraps. Its maximum is STALL_THRESHOLD, which is held in DEADLOCK.
- Outputs are all registered. There is no combinational path from input to output.

Test Plan:
- Reset values: assert reset 3 cycles with random inputs -> block=0, stall_count=0, block_mask=0, first_blocked_idx=10. Repeat from DEADLOCK -> all cleared the cycle after reset.
- Basic deadlock (STALL_THRESHOLD=8): hold axis_block_sigs=10'h104, inst_idle=0 for 12 cycles -> stall_count steps 0,1..7,8. block rises 9 cycles after the vector first appears (1 progress cycle + 8 stall cycles). block_mask=10'h104, first_blocked_idx=2, values frozen afterwards.
- Progress resets count (threshold 8): hold 10'h001 for 6 cycles, change to 10'h002 for 1 cycle, then hold -> count returns to 0 at the change, restarts at 1, and block asserts only after 8 further consecutive stall cycles.
- Idle suppression: axis_block_sigs=10'h300 constant, inst_idle=1 for 50 cycles -> block=0, stall_count=0. Drop inst_idle -> deadlock after threshold with first_blocked_idx=8.
- Instance-only block: axis_block_sigs=0, inst_block_sigs=1 for threshold+2 cycles -> block=1, block_mask=0, first_blocked_idx=10.
- Default threshold: constant 10'h3FF -> block=0 through cycle 1024, block=1 at cycle 1025, stall_count=1024 held.
